// File: rtl/uart_tx_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl_if
//   Bundles the byte-write handshake and the serial-side outputs of the UART
//   transmitter so producer and transmitter connect through one port.
//
//   pi_flag   producer -> tx   one-cycle write strobe
//   pi_data   producer -> tx   byte to transmit, valid while pi_flag is high
//   full      tx -> producer   queue holds FIFO_DEPTH bytes; writes are dropped
//   overflow  tx -> producer   one-cycle pulse the cycle after a dropped write
//   busy      tx -> producer   a frame is on the line (start..stop)
//   tx        tx -> line       serial output, idles high
// ----------------------------------------------------------------------------
interface uart_tx_ctrl_if;
  logic       pi_flag;
  logic [7:0] pi_data;
  logic       full;
  logic       overflow;
  logic       busy;
  logic       tx;

  modport master (
    output pi_flag, pi_data,
    input  full, overflow, busy, tx
  );

  modport slave (
    input  pi_flag, pi_data,
    output full, overflow, busy, tx
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmitter, 8N1, LSB first. Bytes written through the bus are queued
//   in a small FIFO and serialised onto tx at CLK_FREQ/BAUD cycles per bit.
//   Frames go out back-to-back while the FIFO holds data.
//
//   sclk   system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_ctrl_if.slave: pi_flag/pi_data in; full/overflow/busy/tx out
// ----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          sclk,
  input  logic          rst_n,
  uart_tx_ctrl_if.slave bus
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD;
  localparam int BCW          = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int PW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW           = PW + 1;

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(FIFO_DEPTH);

  if (BAUD_CNT_MAX < 2) begin : g_bad_baud
    $error("uart_tx_ctrl: CLK_FREQ/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Control registers (reset)
  state_t          state_q, state_d;
  logic [BCW-1:0]  baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;

  // Data registers (no reset: only read after being loaded)
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem [FIFO_DEPTH];

  logic            full;
  logic            wr_en;
  logic            pop;
  logic            bit_end;

  assign full    = (count_q == CNT_FULL);
  assign wr_en   = bus.pi_flag && !full;
  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Outputs are decoded from next-state values so they land in registers
    // aligned with the state they describe.
    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
    busy_d = (state_d != IDLE);
    ovf_d  = bus.pi_flag && full;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge sclk) begin
    shift_q <= shift_d;
    if (wr_en) mem[wr_ptr_q] <= bus.pi_data;
  end

  assign bus.full     = full;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Self-checking bench for uart_tx_ctrl at 16 cycles per bit, FIFO depth 8.
// ----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int BIT_CYC = 16;
  localparam int DEPTH   = 8;

  logic sclk = 1'b0;
  logic rst_n;

  uart_tx_ctrl_if bus();

  uart_tx_ctrl #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sclk (sclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_seen = 0;

  always @(negedge sclk) if (bus.overflow === 1'b1) ovf_seen++;

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // seq[i] = i-th bit on the line (start first)
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.pi_flag = 1'b1;
    bus.pi_data = b;
    tick();
    bus.pi_flag = 1'b0;
  endtask

  function automatic logic [9:0] fr(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Checks one frame cycle by cycle from the current sample point. skip drops
  // samples of the start bit already elapsed; inj writes inj_b on the last
  // stop-bit cycle (the cycle the next byte is popped).
  task automatic check_frame(input logic [9:0] seq, input string name, input int skip,
                             input bit inj, input logic [7:0] inj_b);
    int bad;
    int ncyc;
    for (int i = 0; i < 10; i++) begin
      bad  = 0;
      ncyc = (i == 0) ? BIT_CYC - skip : BIT_CYC;
      for (int c = 0; c < ncyc; c++) begin
        if (bus.tx !== seq[i] || bus.busy !== 1'b1) bad++;
        if (inj && i == 9 && c == ncyc - 1) begin
          chk({name, " full at pop+write"}, 32'(bus.full), 32'd0);
          bus.pi_flag = 1'b1;
          bus.pi_data = inj_b;
        end
        tick();
        bus.pi_flag = 1'b0;
      end
      chk($sformatf("%s bit%0d bad-cycles", name, i), bad, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad_tx, bad_busy, bad_full, bad_ovf, base;

    vecs[0] = '{data: 8'hA5, seq: 10'b1101001010};
    vecs[1] = '{data: 8'h00, seq: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, seq: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, seq: 10'b1001111000};
    vecs[4] = '{data: 8'h81, seq: 10'b1100000010};

    bus.pi_flag = 1'b0;
    bus.pi_data = 8'h00;
    rst_n       = 1'b0;
    tick();
    tick();
    chk("reset tx",       32'(bus.tx),       32'd1);
    chk("reset busy",     32'(bus.busy),     32'd0);
    chk("reset full",     32'(bus.full),     32'd0);
    chk("reset overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;

    // Idle line after reset
    bad_tx = 0; bad_busy = 0; bad_full = 0; bad_ovf = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (bus.tx !== 1'b1)       bad_tx++;
      if (bus.busy !== 1'b0)     bad_busy++;
      if (bus.full !== 1'b0)     bad_full++;
      if (bus.overflow !== 1'b0) bad_ovf++;
    end
    chk("idle tx bad-cycles",       bad_tx,   0);
    chk("idle busy bad-cycles",     bad_busy, 0);
    chk("idle full bad-cycles",     bad_full, 0);
    chk("idle overflow bad-cycles", bad_ovf,  0);

    // Single-byte frames from the vector table
    for (int v = 0; v < 5; v++) begin
      put(vecs[v].data);
      chk($sformatf("v%0d tx high 1 cycle after strobe", v), 32'(bus.tx), 32'd1);
      chk($sformatf("v%0d busy low 1 cycle after strobe", v), 32'(bus.busy), 32'd0);
      tick();
      chk($sformatf("v%0d busy rises 2 cycles after strobe", v), 32'(bus.busy), 32'd1);
      check_frame(vecs[v].seq, $sformatf("v%0d", v), 0, 1'b0, 8'h00);
      chk($sformatf("v%0d busy low after 160", v), 32'(bus.busy), 32'd0);
      chk($sformatf("v%0d tx idle after frame", v), 32'(bus.tx), 32'd1);
      tick();
      tick();
    end

    // Back-to-back frames, no idle gap
    put(8'h00);
    put(8'hFF);
    check_frame(fr(8'h00), "b2b f1", 0, 1'b0, 8'h00);
    check_frame(fr(8'hFF), "b2b f2", 0, 1'b0, 8'h00);
    chk("b2b busy low after", 32'(bus.busy), 32'd0);
    repeat (4) tick();

    // Overfill: 10 strobes, 10th dropped
    base = ovf_seen;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("ovf full before write %0d", k), 32'(bus.full), (k == 10) ? 32'd1 : 32'd0);
      put(8'(k));
    end
    chk("ovf overflow pulse", 32'(bus.overflow), 32'd1);
    check_frame(fr(8'h01), "ovf f1", 8, 1'b0, 8'h00);
    for (int k = 2; k <= 9; k++)
      check_frame(fr(8'(k)), $sformatf("ovf f%0d", k), 0, 1'b0, 8'h00);
    chk("ovf no 10th frame", 32'(bus.busy), 32'd0);
    chk("ovf pulse count", ovf_seen - base, 1);
    chk("ovf full cleared", 32'(bus.full), 32'd0);
    repeat (4) tick();

    // Write coinciding with pop at count = DEPTH-1
    put(8'h3C);
    for (int k = 1; k <= 7; k++) put(8'h10 + 8'(k));
    check_frame(fr(8'h3C), "wp f0", 6, 1'b1, 8'h5E);
    chk("wp full after pop+write", 32'(bus.full), 32'd0);
    for (int k = 1; k <= 7; k++)
      check_frame(fr(8'h10 + 8'(k)), $sformatf("wp f%0d", k), 0, 1'b0, 8'h00);
    check_frame(fr(8'h5E), "wp f8", 0, 1'b0, 8'h00);
    chk("wp busy low after", 32'(bus.busy), 32'd0);
    repeat (4) tick();

    // Reset during data bit 3 with 3 bytes queued
    put(8'h21);
    put(8'h22);
    put(8'h23);
    put(8'h24);
    repeat (68) tick();
    chk("rst mid tx = data bit3", 32'(bus.tx), 32'd0);
    chk("rst mid busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async tx", 32'(bus.tx), 32'd1);
    chk("rst async busy", 32'(bus.busy), 32'd0);
    chk("rst async full", 32'(bus.full), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bad_tx = 0;
    bad_busy = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.tx !== 1'b1)   bad_tx++;
      if (bus.busy !== 1'b0) bad_busy++;
    end
    chk("post-rst tx bad-cycles", bad_tx, 0);
    chk("post-rst busy bad-cycles", bad_busy, 0);
    put(8'h5A);
    chk("post-rst tx before fall", 32'(bus.tx), 32'd1);
    tick();
    check_frame(fr(8'h5A), "post-rst f", 0, 1'b0, 8'h00);
    chk("post-rst busy low after", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
